turn_ctrl: RTL and testbench
============================

# turn_ctrl

Turn sequencer for the two-player keypad game. It sits between `keypad_scan` (4-bit held key code) and the game display and scoring logic. It detects new key presses and runs a select/confirm move protocol for the active player over a 9-cell board. It tracks cell occupancy and ownership, rejects illegal moves, hands the turn over after each committed move, and optionally forfeits a turn on inactivity.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50_000_000: idle cycles allowed per turn before forfeit (only used with `TURN_TIMEOUT_EN`); must be ≥ 2.
- `CNT_W`, default 26: timeout counter width; 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1: single clock, all logic rising-edge.
- `rst`  in  1: reset, synchronous, active-high.
- `keypad_in`  in  4: held code from `keypad_scan`.
  - 0–9: digits.
  - 10: '*'.
  - 11: '#'.
  - 15: no key.
  - 12–14: reserved, ignored.
- `whose`  out  1: active player (0/1).
- `en`  out  1: one-cycle pulse, move committed.
- `move_cell`  out  4: cell (1–9) of last commit; holds until next commit.
- `sel_valid`  out  1: a cell is selected, awaiting confirm.
- `sel_cell`  out  4: currently selected cell (0 when none).
- `reject`  out  1: one-cycle pulse, selection of occupied cell.
- `timeout`  out  1: one-cycle pulse, turn forfeited.
- `occ`  out  9: bit i-1 set when cell i occupied.
- `owner`  out  9: bit i-1 = player owning cell i (0 if free).
- `done`  out  1: board full.

## Operation
- Press event: `keypad_in != 15` and registered previous code `prev == 15`. `prev` resets to 15 and updates every cycle. Holding a key yields one event; a new event requires release to 15.
- States: SELECT, CONFIRM, DONE. Reset enters SELECT.
- SELECT:
  - Digit 1–9, cell free: latch `sel_cell`, `sel_valid`=1, go to CONFIRM.
  - Digit 1–9, cell occupied: `reject` pulse, stay.
  - Other keys: ignored.
- CONFIRM:
  - '#': commit.
    - Set `occ[c-1]`; set `owner[c-1]=whose`.
    - `move_cell`=c, `en` pulse.
    - Clear selection, toggle `whose`.
    - Go to DONE if all 9 cells are now occupied, else SELECT.
  - '*': clear selection, go to SELECT, `whose` unchanged.
  - Digit 1–9: re-select if free; if occupied, `reject` pulse and keep old selection.
  - '0' and reserved codes: ignored.
- DONE:
  - `done`=1.
  - '*' clears `occ`, `owner`, `move_cell`, sets `whose`=0, goes to SELECT.
  - All else ignored; timeout counter idle.
- Reset mid-operation: every register returns to its reset value at the next edge; pending selection is lost.

## Timing
- Reset values: `whose`=0, `en`=0, `move_cell`=0, `sel_valid`=0, `sel_cell`=0, `reject`=0, `timeout`=0, `occ`=0, `owner`=0, `done`=0, state SELECT, counter 0.
- Latency: the event is evaluated at the first rising edge where the new code is present. All outputs reflect the result in the following cycle, i.e. 1 cycle.
- `en`, `reject`, `timeout` are registered single-cycle pulses.
- Two presses need at least one intervening 15 sample; a direct code-to-code change without 15 is not an event.
- `whose` toggles in the same cycle `en` or `timeout` is high.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - Counter runs in SELECT/CONFIRM and clears on any press event, commit, or turn change.
  - When counter == TIMEOUT_CYCLES-1 with no event that cycle:
    - `timeout` pulse, `whose` toggles, selection cleared.
    - State goes to SELECT, counter returns to 0.
  - A press event in the expiry cycle wins; no timeout.
- `TURN_TIMEOUT_EN` not defined:
  - No counter is synthesized; `timeout` is tied 0.
  - Turns never expire.

## Test plan
- Reset, then press 5, release, press '#' → `en` pulse, `move_cell`=5, `occ`=9'b000010000, `owner`=0, `whose`=1.
- Player 1 presses 5 → `reject` pulse, state SELECT. Then 3, '*' → `sel_valid`=0, `whose` still 1. Then 3, '#' → `owner[2]`=1, `whose`=0.
- Hold key 7 for 20 cycles → exactly one event, `sel_cell`=7. Change 7→8 without a release → no event.
- Fill all 9 cells with alternating commits → `done`=1 after the 9th `en`, `whose` toggled. Digits are then ignored. '*' → `occ`=0, `owner`=0, `whose`=0, `done`=0.
- With `TURN_TIMEOUT_EN`, TIMEOUT_CYCLES=8: select 2, then idle → `timeout` pulse 8 cycles after the press, `sel_valid`=0, `whose` toggled. Press on the expiry cycle → no timeout.
- Assert `rst` while in CONFIRM with 4 selected → all outputs at reset values next cycle.

Source files
------------

// File: rtl/turn_ctrl_if.sv
// turn_ctrl_if: signal bundle between the keypad side and the turn sequencer.
//
// Handshake: there is no valid/ready pair. keypad_in is a level (held key
// code, 15 = no key) sampled every rising edge; the sequencer turns a
// 15 -> non-15 transition into a single press event. en, reject and timeout
// are single-cycle registered pulses; every other output is a held level.
//
// Modports:
//   master - keypad/game side: drives keypad_in, observes everything else.
//   slave  - turn_ctrl: reads keypad_in, drives the game outputs and state.
//
// Signals:
//   keypad_in [3:0]  held key code (0-9 digits, 10 '*', 11 '#', 15 none)
//   whose            active player
//   en               move committed pulse
//   move_cell [3:0]  cell of the last commit
//   sel_valid        a cell is selected and awaits confirm
//   sel_cell  [3:0]  selected cell, 0 when none
//   reject           occupied-cell selection pulse
//   timeout          turn forfeited pulse
//   occ       [8:0]  occupancy, bit i-1 for cell i
//   owner     [8:0]  owning player per cell, 0 when free
//   done             board full
//   state     [1:0]  FSM state for observation (0 SELECT, 1 CONFIRM, 2 DONE)
interface turn_ctrl_if;
    logic [3:0] keypad_in;
    logic       whose;
    logic       en;
    logic [3:0] move_cell;
    logic       sel_valid;
    logic [3:0] sel_cell;
    logic       reject;
    logic       timeout;
    logic [8:0] occ;
    logic [8:0] owner;
    logic       done;
    logic [1:0] state;

    modport master (
        output keypad_in,
        input  whose, en, move_cell, sel_valid, sel_cell, reject,
        input  timeout, occ, owner, done, state
    );

    modport slave (
        input  keypad_in,
        output whose, en, move_cell, sel_valid, sel_cell, reject,
        output timeout, occ, owner, done, state
    );
endinterface

// File: rtl/turn_ctrl.sv
// turn_ctrl: turn sequencer for the two-player keypad game.
//
// Detects key press events, runs the select/confirm move protocol for the
// active player on a 9-cell board, tracks occupancy and ownership, rejects
// moves onto occupied cells and hands the turn over after each commit.
//
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYCLES idle cycles. Without it no counter exists and timeout is 0.
//
// Ports:
//   clk  - single rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - turn_ctrl_if.slave (keypad_in in; game outputs and FSM state out)
//
// Parameters:
//   TIMEOUT_CYCLES - idle cycles per turn before forfeit (>= 2)
//   CNT_W          - timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
module turn_ctrl #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26
) (
    input logic        clk,
    input logic        rst,
    turn_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_SELECT  = 2'd0,
        S_CONFIRM = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;

    if ((TIMEOUT_CYCLES < 2) || ((TIMEOUT_CYCLES >> CNT_W) != 0)) begin : g_param_check
        $error("turn_ctrl: TIMEOUT_CYCLES must be >= 2 and fit in CNT_W bits");
    end

    state_t     state;
    logic [3:0] prev;
    logic       whose;
    logic       en;
    logic       reject;
    logic       sel_valid;
    logic       done;
    logic [3:0] sel_cell;
    logic [3:0] move_cell;
    logic [8:0] occ;
    logic [8:0] owner;

    logic       press;
    logic       is_digit;
    logic       key_free;
    logic [8:0] key_mask;
    logic [8:0] sel_mask;
    logic [8:0] occ_next;

    // Only a release-to-press transition counts; holding or sliding from one
    // code to another without passing through 15 is not an event.
    assign press    = (bus.keypad_in != KEY_NONE) && (prev == KEY_NONE);
    assign is_digit = (bus.keypad_in >= 4'd1) && (bus.keypad_in <= 4'd9);
    assign key_mask = is_digit ? (9'd1 << (bus.keypad_in - 4'd1)) : 9'd0;
    assign key_free = (occ & key_mask) == 9'd0;
    // sel_cell is always 1-9 while in CONFIRM, which is the only place this is used.
    assign sel_mask = 9'd1 << (sel_cell - 4'd1);
    assign occ_next = occ | sel_mask;

    logic expire;

`ifdef TURN_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    // A press in the expiry cycle takes priority over the forfeit.
    assign expire = (state != S_DONE) && !press && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
            // Every event (including commit, which is a press) restarts the turn timer.
            if ((state == S_DONE) || press || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_SELECT;
            prev      <= KEY_NONE;
            whose     <= 1'b0;
            en        <= 1'b0;
            reject    <= 1'b0;
            sel_valid <= 1'b0;
            sel_cell  <= 4'd0;
            move_cell <= 4'd0;
            occ       <= 9'd0;
            owner     <= 9'd0;
            done      <= 1'b0;
        end else begin
            prev   <= bus.keypad_in;
            en     <= 1'b0;
            reject <= 1'b0;
            if (expire) begin
                whose     <= ~whose;
                sel_valid <= 1'b0;
                sel_cell  <= 4'd0;
                state     <= S_SELECT;
            end else if (press) begin
                case (state)
                    S_SELECT: begin
                        if (is_digit) begin
                            if (key_free) begin
                                sel_cell  <= bus.keypad_in;
                                sel_valid <= 1'b1;
                                state     <= S_CONFIRM;
                            end else begin
                                reject <= 1'b1;
                            end
                        end
                    end
                    S_CONFIRM: begin
                        if (bus.keypad_in == KEY_HASH) begin
                            occ       <= occ_next;
                            owner     <= whose ? (owner | sel_mask) : owner;
                            move_cell <= sel_cell;
                            en        <= 1'b1;
                            sel_valid <= 1'b0;
                            sel_cell  <= 4'd0;
                            whose     <= ~whose;
                            if (occ_next == 9'h1FF) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_SELECT;
                            end
                        end else if (bus.keypad_in == KEY_STAR) begin
                            sel_valid <= 1'b0;
                            sel_cell  <= 4'd0;
                            state     <= S_SELECT;
                        end else if (is_digit) begin
                            if (key_free) begin
                                sel_cell <= bus.keypad_in;
                            end else begin
                                reject <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (bus.keypad_in == KEY_STAR) begin
                            occ       <= 9'd0;
                            owner     <= 9'd0;
                            move_cell <= 4'd0;
                            whose     <= 1'b0;
                            done      <= 1'b0;
                            state     <= S_SELECT;
                        end
                    end
                    default: state <= S_SELECT;
                endcase
            end
        end
    end

    assign bus.whose     = whose;
    assign bus.en        = en;
    assign bus.move_cell = move_cell;
    assign bus.sel_valid = sel_valid;
    assign bus.sel_cell  = sel_cell;
    assign bus.reject    = reject;
    assign bus.occ       = occ;
    assign bus.owner     = owner;
    assign bus.done      = done;
    assign bus.state     = state;
endmodule

// File: tb/tb_turn_ctrl.sv
// tb_turn_ctrl: directed bench for turn_ctrl. Commits are scoreboarded as
// {occ, owner, move_cell, whose} expected after each '#' press.
module tb_turn_ctrl;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [31:0] exp_q[$];

    logic [8:0] m_occ;
    logic [8:0] m_owner;
    logic       m_whose;

`ifdef TURN_TIMEOUT_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 20;
`endif

    turn_ctrl_if bus ();

    turn_ctrl #(
        .TIMEOUT_CYCLES(8),
        .CNT_W         (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        bus.keypad_in = k;
        tick();
    endtask

    task automatic release_key();
        bus.keypad_in = 4'd15;
        tick();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_whose"}, 32'(bus.whose), 32'd0);
        chk({tag, "_en"}, 32'(bus.en), 32'd0);
        chk({tag, "_move_cell"}, 32'(bus.move_cell), 32'd0);
        chk({tag, "_sel_valid"}, 32'(bus.sel_valid), 32'd0);
        chk({tag, "_sel_cell"}, 32'(bus.sel_cell), 32'd0);
        chk({tag, "_reject"}, 32'(bus.reject), 32'd0);
        chk({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
        chk({tag, "_occ"}, 32'(bus.occ), 32'd0);
        chk({tag, "_owner"}, 32'(bus.owner), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
    endtask

    // Select cell c, confirm with '#', compare the committed snapshot.
    task automatic do_commit(input logic [3:0] c, input string tag);
        logic [8:0]  mask;
        logic [31:0] exp_v;
        press(c);
        chk({tag, "_sel"}, 32'(bus.sel_cell), 32'(c));
        release_key();
        mask = 9'd1 << (c - 4'd1);
        m_occ = m_occ | mask;
        if (m_whose) m_owner = m_owner | mask;
        m_whose = ~m_whose;
        exp_q.push_back({9'd0, m_occ, m_owner, c, m_whose});
        press(4'd11);
        chk({tag, "_en"}, 32'(bus.en), 32'd1);
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk({tag, "_snapshot"}, {9'd0, bus.occ, bus.owner, bus.move_cell, bus.whose}, exp_v);
        end
        chk({tag, "_sel_clear"}, 32'(bus.sel_valid), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'(m_occ == 9'h1FF));
        release_key();
        chk({tag, "_en_pulse"}, 32'(bus.en), 32'd0);
    endtask

    initial begin
        int rej_cnt;
        n_assert = 0;
        n_fail   = 0;
        m_occ    = 9'd0;
        m_owner  = 9'd0;
        m_whose  = 1'b0;
        rst = 1'b1;
        bus.keypad_in = 4'd15;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // First move: player 0 takes cell 5.
        press(4'd5);
        chk("p0_sel_valid", 32'(bus.sel_valid), 32'd1);
        chk("p0_state_confirm", 32'(bus.state), 32'd1);
        release_key();
        exp_q.push_back({9'd0, 9'b000010000, 9'd0, 4'd5, 1'b1});
        m_occ = 9'b000010000;
        m_whose = 1'b1;
        press(4'd11);
        chk("p0_commit_en", 32'(bus.en), 32'd1);
        chk("p0_commit_snapshot", {9'd0, bus.occ, bus.owner, bus.move_cell, bus.whose}, exp_q.pop_front());
        release_key();
        chk("p0_en_pulse", 32'(bus.en), 32'd0);

        // Player 1: occupied reject, cancel, then commit cell 3.
        press(4'd5);
        chk("p1_reject", 32'(bus.reject), 32'd1);
        chk("p1_reject_state", 32'(bus.state), 32'd0);
        release_key();
        chk("p1_reject_pulse", 32'(bus.reject), 32'd0);
        press(4'd3);
        release_key();
        press(4'd10);
        chk("p1_cancel_sel", 32'(bus.sel_valid), 32'd0);
        chk("p1_cancel_whose", 32'(bus.whose), 32'd1);
        chk("p1_cancel_state", 32'(bus.state), 32'd0);
        release_key();
        do_commit(4'd3, "p1_c3");
        chk("p1_owner3", 32'(bus.owner[2]), 32'd1);

        // Holding an occupied key yields exactly one reject.
        rej_cnt = 0;
        bus.keypad_in = 4'd5;
        for (int i = 0; i < HOLD; i++) begin
            tick();
            if (bus.reject) rej_cnt++;
        end
        chk("hold_one_reject", 32'(rej_cnt), 32'd1);
        release_key();

        // Hold 7, slide to 8 without release: no second event.
        bus.keypad_in = 4'd7;
        for (int i = 0; i < HOLD; i++) tick();
        chk("hold7_sel", 32'(bus.sel_cell), 32'd7);
        press(4'd8);
        chk("slide_no_event", 32'(bus.sel_cell), 32'd7);
        release_key();
        press(4'd8);
        chk("confirm_reselect", 32'(bus.sel_cell), 32'd8);
        release_key();
        press(4'd5);
        chk("confirm_rej", 32'(bus.reject), 32'd1);
        chk("confirm_rej_keep", 32'(bus.sel_cell), 32'd8);
        release_key();
        press(4'd0);
        chk("confirm_zero_ign", 32'(bus.sel_cell), 32'd8);
        release_key();
        press(4'd13);
        chk("confirm_rsvd_ign", 32'(bus.sel_cell), 32'd8);
        release_key();
        press(4'd10);
        release_key();

        // Fill the board.
        do_commit(4'd1, "fill1");
        do_commit(4'd2, "fill2");
        do_commit(4'd4, "fill4");
        do_commit(4'd6, "fill6");
        do_commit(4'd7, "fill7");
        do_commit(4'd8, "fill8");
        do_commit(4'd9, "fill9");
        chk("full_done", 32'(bus.done), 32'd1);
        chk("full_state", 32'(bus.state), 32'd2);
        chk("full_whose", 32'(bus.whose), 32'd1);
        press(4'd1);
        chk("done_digit_sel", 32'(bus.sel_valid), 32'd0);
        chk("done_digit_rej", 32'(bus.reject), 32'd0);
        chk("done_digit_state", 32'(bus.state), 32'd2);
        release_key();
        press(4'd10);
        m_occ = 9'd0;
        m_owner = 9'd0;
        m_whose = 1'b0;
        chk("clear_occ", 32'(bus.occ), 32'(m_occ));
        chk("clear_owner", 32'(bus.owner), 32'(m_owner));
        chk("clear_whose", 32'(bus.whose), 32'(m_whose));
        chk("clear_done", 32'(bus.done), 32'd0);
        chk("clear_move", 32'(bus.move_cell), 32'd0);
        chk("clear_state", 32'(bus.state), 32'd0);
        release_key();

`ifdef TURN_TIMEOUT_EN
        press(4'd2);
        chk("to_sel", 32'(bus.sel_cell), 32'd2);
        release_key();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("to_early", 32'(bus.timeout), 32'd0);
        end
        tick();
        m_whose = ~m_whose;
        chk("to_pulse", 32'(bus.timeout), 32'd1);
        chk("to_sel_valid", 32'(bus.sel_valid), 32'd0);
        chk("to_whose", 32'(bus.whose), 32'(m_whose));
        chk("to_state", 32'(bus.state), 32'd0);
        tick();
        chk("to_pulse_end", 32'(bus.timeout), 32'd0);
        press(4'd2);
        release_key();
        for (int i = 0; i < 6; i++) tick();
        press(4'd4);
        chk("to_race_none", 32'(bus.timeout), 32'd0);
        chk("to_race_sel", 32'(bus.sel_cell), 32'd4);
        chk("to_race_whose", 32'(bus.whose), 32'(m_whose));
        release_key();
        chk("to_race_after", 32'(bus.timeout), 32'd0);
`else
        press(4'd2);
        release_key();
        for (int i = 0; i < 12; i++) tick();
        chk("no_to_pulse", 32'(bus.timeout), 32'd0);
        chk("no_to_sel", 32'(bus.sel_cell), 32'd2);
        press(4'd4);
        chk("no_to_resel", 32'(bus.sel_cell), 32'd4);
        release_key();
`endif

        // Reset while in CONFIRM with 4 selected.
        chk("pre_rst_state", 32'(bus.state), 32'd1);
        rst = 1'b1;
        tick();
        check_reset("mid_rst");
        rst = 1'b0;
        tick();
        chk("post_rst_state", 32'(bus.state), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
